// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
//   dmem_arb_state_e : arbiter FSM states (IDLE, BUSY).
//   rr_pick()        : round-robin winner search starting at a priority pointer.
//   DMEM_BE_W        : byte-enable width for the default 32-bit data path.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } dmem_arb_state_e;

  localparam int DMEM_DW    = 32;
  localparam int DMEM_BE_W  = DMEM_DW / 8;

  // Widest request vector rr_pick can scan; requester counts above this are unsupported.
  localparam int RR_MAX_REQ = 32;

  // First index i with req[i]=1, scanning ptr, ptr+1, ... mod n. Returns 0 when no request.
  function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        if (!found && req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Round-robin requester selection with its priority pointer.
//   clk, rst : clock and synchronous active-high reset (pointer returns to 0).
//   req      : per-requester request vector.
//   advance  : a grant to win is taken this cycle; pointer moves past the winner.
//   win      : index of the selected requester (valid when any_req).
//   any_req  : at least one request is pending.
module rr_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NREQ-1:0]                         req,
  input  logic                                    advance,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] win,
  output logic                                    any_req
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;

  always_comb begin
    any_req = |req;
    win     = PW'(rr_pick(RR_MAX_REQ'(req), 32'(ptr), NREQ));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PW'((32'(win) + 32'd1) % NREQ);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port, fixed-latency data memory.
// One access is outstanding at a time; with MEM_LAT=1 grants pipeline back to back.
//   clk, rst   : clock and synchronous active-high reset (all outputs 0 while rst=1).
//   req/we/addr/wdata/be : per-requester access, packed, requester i in slice i.
//   gnt        : one-hot grant pulse, access accepted this cycle.
//   rvalid     : one-hot completion pulse to the access owner.
//   rdata      : shared read data, qualified by rvalid.
//   busy       : an access is outstanding.
//   mem_*      : memory-side strobe, write enable, address, data, byte enables, read data.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*AW-1:0]       addr,
  input  logic [NREQ*DW-1:0]       wdata,
  input  logic [NREQ*(DW/8)-1:0]   be,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DW-1:0]            rdata,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [(DW/8)-1:0]        mem_be,
  input  logic [DW-1:0]            mem_rdata
);

  localparam int BW = DW / 8;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MEM_LAT + 1);

  dmem_arb_state_e state, state_nxt;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            last_cycle;
  logic            accept_ok;
  logic            grant;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (grant),
    .win     (win),
    .any_req (any_req)
  );

  // Grant and completion are gated by rst so every output reads 0 during reset,
  // including the cycle where rst rises mid-access (that access is abandoned).
  always_comb begin
    last_cycle = (state == BUSY) && (cnt == CW'(1));
    accept_ok  = (state == IDLE) || last_cycle;
    grant      = !rst && accept_ok && any_req;
    busy       = !rst && (state == BUSY);

    gnt       = '0;
    rvalid    = '0;
    rdata     = '0;
    mem_req   = grant;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant && (win == PW'(i))) begin
        gnt[i]    = 1'b1;
        mem_we    = we[i];
        mem_addr  = addr[i*AW +: AW];
        mem_wdata = wdata[i*DW +: DW];
        mem_be    = be[i*BW +: BW];
      end
      if (!rst && last_cycle && (owner == PW'(i))) begin
        rvalid[i] = 1'b1;
      end
    end
    if (!rst && last_cycle) begin
      rdata = mem_rdata;
    end

    state_nxt = state;
    if (grant) begin
      state_nxt = BUSY;
    end else if (last_cycle) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner <= win;
        cnt   <= CW'(MEM_LAT);
      end else if (state == BUSY) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: NREQ=2, MEM_LAT=1 ----------------
  logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_rvalid;
  logic [63:0] a_addr = {32'h104, 32'h100};
  logic [63:0] a_wdata = '0;
  logic [7:0]  a_be = '0;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_busy, a_mem_req, a_mem_we;
  logic [3:0]  a_mem_be;
  logic [31:0] a_mem [0:255];
  logic [31:0] a_d1;

  dmem_arbiter #(.NREQ(2), .AW(32), .DW(32), .MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata), .be(a_be),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .busy(a_busy),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      a_mem[64] <= 32'hDEADBEEF;
      a_mem[65] <= 32'hCAFEF00D;
    end
    a_d1 <= a_mem[a_mem_addr[9:2]];
  end
  assign a_mem_rdata = a_d1;

  // Scoreboard: {rvalid one-hot, rdata} expected per access, pushed when driven.
  logic [33:0] sbq[$];
  logic [33:0] sb_e;
  always @(negedge clk) begin
    if (!rst && a_rvalid != 2'b00) begin
      if (sbq.size() == 0) begin
        chk("sb_extra_rvalid", 64'(a_rvalid), 64'd0);
      end else begin
        sb_e = sbq.pop_front();
        chk("sb_rvalid", 64'(a_rvalid), 64'(sb_e[33:32]));
        chk("sb_rdata", 64'(a_rdata), 64'(sb_e[31:0]));
      end
    end
  end

  // ---------------- instance B: NREQ=2, MEM_LAT=3 ----------------
  logic [1:0]  b_req = '0, b_we = '0, b_gnt, b_rvalid;
  logic [63:0] b_addr = {32'h40, 32'h40};
  logic [63:0] b_wdata = {32'h12345678, 32'hFFFFFFFF};
  logic [7:0]  b_be = {4'b0011, 4'b1111};
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_busy, b_mem_req, b_mem_we;
  logic [3:0]  b_mem_be;
  logic [31:0] b_mem [0:255];
  logic [31:0] b_d1, b_d2, b_d3;

  dmem_arbiter #(.NREQ(2), .AW(32), .DW(32), .MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata), .be(b_be),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .busy(b_busy),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
  );

  always @(posedge clk) begin
    if (rst) begin
      b_mem[16] <= 32'hAAAAAAAA;
    end else if (b_mem_req && b_mem_we) begin
      for (int k = 0; k < 4; k++)
        if (b_mem_be[k]) b_mem[b_mem_addr[9:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
    end
    b_d1 <= b_mem[b_mem_addr[9:2]];
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign b_mem_rdata = b_d3;

  // ---------------- instance C: NREQ=3, MEM_LAT=1 ----------------
  logic [2:0]  c_req = '0, c_we = '0, c_gnt, c_rvalid;
  logic [95:0] c_addr = '0, c_wdata = '0;
  logic [11:0] c_be = '0;
  logic [31:0] c_rdata, c_mem_addr, c_mem_wdata;
  logic        c_busy, c_mem_req, c_mem_we;
  logic [3:0]  c_mem_be;
  logic [31:0] c_mem_rdata = 32'h0;

  dmem_arbiter #(.NREQ(3), .AW(32), .DW(32), .MEM_LAT(1)) u_c (
    .clk(clk), .rst(rst), .req(c_req), .we(c_we), .addr(c_addr), .wdata(c_wdata), .be(c_be),
    .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata), .busy(c_busy),
    .mem_req(c_mem_req), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_be(c_mem_be), .mem_rdata(c_mem_rdata)
  );

  initial begin
    // Reset held 2 cycles with every requester asking.
    a_req = 2'b11; b_req = 2'b11; c_req = 3'b111;
    for (int i = 0; i < 2; i++) begin
      cyc(); #3;
      chk("rst_a_gnt", 64'(a_gnt), 64'd0);
      chk("rst_a_rvalid", 64'(a_rvalid), 64'd0);
      chk("rst_a_mem_req", 64'(a_mem_req), 64'd0);
      chk("rst_a_busy", 64'(a_busy), 64'd0);
      chk("rst_b_gnt", 64'(b_gnt), 64'd0);
      chk("rst_c_gnt", 64'(c_gnt), 64'd0);
    end

    // A: both requesting for 6 cycles -> strict alternation from req0.
    cyc(); rst = 1'b0; b_req = '0; c_req = '0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) cyc();
      sbq.push_back((i % 2 == 0) ? {2'b01, 32'hDEADBEEF} : {2'b10, 32'hCAFEF00D});
      #3;
      chk("a_rr_gnt", 64'(a_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("a_rr_mem_req", 64'(a_mem_req), 64'd1);
      chk("a_rr_mem_addr", 64'(a_mem_addr), (i % 2 == 0) ? 64'h100 : 64'h104);
    end
    cyc(); a_req = 2'b00; #3;
    chk("a_idle_gnt", 64'(a_gnt), 64'd0);
    chk("a_idle_mem_req", 64'(a_mem_req), 64'd0);
    chk("a_idle_mem_addr", 64'(a_mem_addr), 64'd0);

    // A: single read of 0x100.
    cyc(); a_req = 2'b01; sbq.push_back({2'b01, 32'hDEADBEEF}); #3;
    chk("a_rd_gnt", 64'(a_gnt), 64'd1);
    chk("a_rd_addr", 64'(a_mem_addr), 64'h100);
    cyc(); a_req = 2'b00; #3;
    chk("a_rd_rvalid", 64'(a_rvalid), 64'd1);
    chk("a_rd_rdata", 64'(a_rdata), 64'hDEADBEEF);
    chk("a_rd_gnt_after", 64'(a_gnt), 64'd0);
    // Pointer now favours req1; a lone req0 still wins.
    cyc(); a_req = 2'b01; sbq.push_back({2'b01, 32'hDEADBEEF}); #3;
    chk("a_single_req_ptr1", 64'(a_gnt), 64'd1);
    cyc(); a_req = 2'b00;
    cyc(); #3;
    chk("a_sb_drained", 64'(sbq.size()), 64'd0);

    // B: req1 write, MEM_LAT=3, req0 waiting behind it.
    cyc(); b_req = 2'b10; b_we = 2'b10; #3;
    chk("b_wr_gnt", 64'(b_gnt), 64'd2);
    chk("b_wr_mem_we", 64'(b_mem_we), 64'd1);
    chk("b_wr_mem_be", 64'(b_mem_be), 64'b0011);
    chk("b_wr_mem_addr", 64'(b_mem_addr), 64'h40);
    chk("b_wr_mem_wdata", 64'(b_mem_wdata), 64'h12345678);
    cyc(); b_req = 2'b01; b_we = 2'b00; #3;
    chk("b_t1_gnt", 64'(b_gnt), 64'd0);
    chk("b_t1_busy", 64'(b_busy), 64'd1);
    chk("b_t1_rvalid", 64'(b_rvalid), 64'd0);
    cyc(); #3;
    chk("b_t2_gnt", 64'(b_gnt), 64'd0);
    chk("b_t2_busy", 64'(b_busy), 64'd1);
    chk("b_t2_rvalid", 64'(b_rvalid), 64'd0);
    cyc(); #3;
    chk("b_t3_rvalid", 64'(b_rvalid), 64'd2);
    chk("b_t3_gnt", 64'(b_gnt), 64'd1);
    chk("b_t3_busy", 64'(b_busy), 64'd1);
    cyc(); b_req = 2'b00; #3;
    chk("b_t4_busy", 64'(b_busy), 64'd1);
    chk("b_t4_rvalid", 64'(b_rvalid), 64'd0);
    cyc(); #3;
    chk("b_t5_busy", 64'(b_busy), 64'd1);
    cyc(); #3;
    chk("b_rd_rvalid", 64'(b_rvalid), 64'd1);
    chk("b_rd_rdata", 64'(b_rdata), 64'hAAAA5678);
    cyc(); #3;
    chk("b_done_busy", 64'(b_busy), 64'd0);
    chk("b_done_rvalid", 64'(b_rvalid), 64'd0);

    // B: reset one cycle after a grant to req0 abandons the access.
    cyc(); b_req = 2'b01; #3;
    chk("b_rs_gnt", 64'(b_gnt), 64'd1);
    cyc(); rst = 1'b1; b_req = 2'b00; #3;
    chk("b_rs_t1_busy", 64'(b_busy), 64'd0);
    chk("b_rs_t1_rvalid", 64'(b_rvalid), 64'd0);
    cyc(); rst = 1'b0; #3;
    chk("b_rs_t2_busy", 64'(b_busy), 64'd0);
    chk("b_rs_t2_rvalid", 64'(b_rvalid), 64'd0);
    cyc(); #3;
    chk("b_rs_t3_rvalid", 64'(b_rvalid), 64'd0);
    chk("b_rs_t3_busy", 64'(b_busy), 64'd0);
    cyc(); b_req = 2'b11; #3;
    chk("b_rs_first_gnt", 64'(b_gnt), 64'd1);
    cyc(); b_req = 2'b00; #3;
    chk("b_rs_gnt_drop", 64'(b_gnt), 64'd0);
    cyc(); cyc(); cyc();

    // C: NREQ=3, req1 never asserted.
    cyc(); c_req = 3'b001; #3;
    chk("c_gnt0", 64'(c_gnt), 64'b001);
    cyc(); c_req = 3'b101; #3;
    chk("c_gnt_skip1", 64'(c_gnt), 64'b100);
    chk("c_rvalid0", 64'(c_rvalid), 64'b001);
    cyc(); #3;
    chk("c_gnt_wrap", 64'(c_gnt), 64'b001);
    chk("c_rvalid2", 64'(c_rvalid), 64'b100);
    cyc(); #3;
    chk("c_gnt_again2", 64'(c_gnt), 64'b100);
    cyc(); c_req = 3'b000; #3;
    chk("c_gnt_none", 64'(c_gnt), 64'b000);
    chk("c_rvalid_last", 64'(c_rvalid), 64'b100);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
